clk_tick_gen: RTL and testbench

- Multi-channel programmable clock-enable generator: each of NUM_CH channels divides the system clock by its own runtime-loadable divisor.
- Each channel produces a one-cycle tick strobe and a 50% toggle output.
- Feeds the traffic-light FSM timers, e.g. a 1 s state tick, a fast blink tick and a pedestrian-countdown tick, from one shared clock domain.
- Replaces single-purpose fixed 1 s dividers.

---
 rtl/clk_tick_gen.sv | 92 +++++++++
 tb/tb_clk_tick_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen.sv
// ---------------------------------------------------------------------------
// clk_tick_gen
//
// Multi-channel programmable clock-enable generator. Each of NUM_CH channels
// divides the system clock by its own runtime-loadable divisor. Every channel
// produces a one-cycle tick strobe and a 50% duty toggle output with a period
// of 2*div. Typical users are the traffic-light FSM timers: a 1 s state tick,
// a fast blink tick and a pedestrian-countdown tick, all in one clock domain.
//
// Ports
//   clock   : system clock, all logic on the rising edge
//   rst     : synchronous, active-high reset (cnt=0, div=DEF_DIV, outputs 0)
//   en      : global run enable; low freezes every channel
//   ch_en   : per-channel run enable
//   load    : per-channel divisor load strobe (accepted even when not running)
//   div_in  : shared divisor value written by any asserted load bit
//   tick    : registered one-cycle strobe per channel
//   clk_out : registered toggle output per channel, period 2*div
//   active  : registered; high when the channel runs with a nonzero divisor
// ---------------------------------------------------------------------------
module clk_tick_gen #(
    parameter int unsigned      NUM_CH  = 3,
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(50000000)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] load,
    input  logic [CNT_W-1:0]  div_in,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] active
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic             tick_q;
        logic             clk_q;
        logic             act_q;
        logic             run;
        logic             at_term;

        // Terminal-count compare is only meaningful with a nonzero divisor;
        // with div=0 the channel is stalled and div-1 would wrap.
        always_comb begin
            run     = en & ch_en[g] & (div != '0);
            at_term = 1'b0;
            if (div != '0) begin
                at_term = (cnt == div - CNT_W'(1));
            end
        end

        always_ff @(posedge clock) begin
            if (rst) begin
                cnt    <= '0;
                div    <= DEF_DIV;
                tick_q <= 1'b0;
                clk_q  <= 1'b0;
                act_q  <= 1'b0;
            end else if (load[g]) begin
                // Load beats a coincident terminal count: no tick, no toggle.
                // active reflects the divisor being written, not the old one.
                div    <= div_in;
                cnt    <= '0;
                tick_q <= 1'b0;
                act_q  <= en & ch_en[g] & (div_in != '0);
            end else if (run) begin
                act_q <= 1'b1;
                if (at_term) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    clk_q  <= ~clk_q;
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                end
            end else begin
                // Hold: count and phase frozen so a re-enable resumes in place.
                tick_q <= 1'b0;
                act_q  <= 1'b0;
            end
        end

        assign tick[g]    = tick_q;
        assign clk_out[g] = clk_q;
        assign active[g]  = act_q;
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_tick_gen
//
// Directed bench for clk_tick_gen (NUM_CH=3, CNT_W=8, DEF_DIV=6). Stimulus
// pushes the expected outputs after each edge into a queue; a monitor pops
// and compares on the following falling edge.
// Expected tick/clk_out after the k-th enabled edge since a load or reset,
// for divisor d: tick = (k % d == 0), clk_out = start ^ ((k / d) odd).
// ---------------------------------------------------------------------------
module tb_clk_tick_gen;

    logic       clock;
    logic       rst;
    logic       en;
    logic [2:0] ch_en;
    logic [2:0] load;
    logic [7:0] div_in;
    logic [2:0] tick;
    logic [2:0] clk_out;
    logic [2:0] active;

    clk_tick_gen #(
        .NUM_CH  (3),
        .CNT_W   (8),
        .DEF_DIV (8'd6)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .en      (en),
        .ch_en   (ch_en),
        .load    (load),
        .div_in  (div_in),
        .tick    (tick),
        .clk_out (clk_out),
        .active  (active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] e_tick;
        logic [2:0] e_clk;
        logic [2:0] e_act;
        logic [2:0] mask;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] exp_tick;
    logic [2:0] exp_clk;
    logic [2:0] exp_act;

    // Expected state of channel i after the k-th enabled edge with divisor d.
    task automatic set_ch(input int i, input int d, input int k,
                          input logic c0, input logic a);
        exp_tick[i] = (k > 0) && ((k % d) == 0);
        exp_clk[i]  = c0 ^ (((k / d) % 2) == 1);
        exp_act[i]  = a;
    endtask

    task automatic set_hold(input int i, input logic c, input logic a);
        exp_tick[i] = 1'b0;
        exp_clk[i]  = c;
        exp_act[i]  = a;
    endtask

    task automatic step(input string nm, input logic [2:0] m);
        exp_t e;
        @(posedge clock);
        #1;
        e.e_tick = exp_tick;
        e.e_clk  = exp_clk;
        e.e_act  = exp_act;
        e.mask   = m;
        e.name   = nm;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if ((((tick ^ e.e_tick) | (clk_out ^ e.e_clk) | (active ^ e.e_act)) & e.mask) != 3'b000) begin
                miscompares++;
                $display("FAIL %s @%0t: tick=%b clk_out=%b active=%b, expected tick=%b clk_out=%b active=%b (mask %b)",
                         e.name, $time, tick, clk_out, active, e.e_tick, e.e_clk, e.e_act, e.mask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; ch_en = 3'b000; load = 3'b000; div_in = 8'd0;
        for (int i = 0; i < 3; i++) set_hold(i, 1'b0, 1'b0);
        step("reset", 3'b111);
        step("reset", 3'b111);

        // ch0 divide by 4: tick every 4 clocks, clk_out period 8
        rst = 1'b0; en = 1'b1; ch_en = 3'b001; load = 3'b001; div_in = 8'd4;
        set_hold(0, 1'b0, 1'b1);
        step("load4", 3'b111);
        load = 3'b000;
        for (int k = 1; k <= 16; k++) begin
            set_ch(0, 4, k, 1'b0, 1'b1);
            step("div4", 3'b111);
        end

        // simultaneous load of 3 into all channels
        ch_en = 3'b111; load = 3'b111; div_in = 8'd3;
        for (int i = 0; i < 3; i++) set_hold(i, 1'b0, 1'b1);
        step("simload", 3'b111);
        load = 3'b000;
        for (int k = 1; k <= 6; k++) begin
            for (int i = 0; i < 3; i++) set_ch(i, 3, k, 1'b0, 1'b1);
            step("simload_run", 3'b111);
        end

        // separate loads while disabled: 3, 5, 1
        ch_en = 3'b000;
        for (int i = 0; i < 3; i++) set_hold(i, 1'b0, 1'b0);
        load = 3'b001; div_in = 8'd3; step("ld_ch0", 3'b111);
        load = 3'b010; div_in = 8'd5; step("ld_ch1", 3'b111);
        load = 3'b100; div_in = 8'd1; step("ld_ch2", 3'b111);
        load = 3'b000; ch_en = 3'b111;
        for (int k = 1; k <= 15; k++) begin
            set_ch(0, 3, k, 1'b0, 1'b1);
            set_ch(1, 5, k, 1'b0, 1'b1);
            set_ch(2, 1, k, 1'b0, 1'b1);
            step("indep", 3'b111);
        end

        // ch_en pause at cnt=2, then resume
        ch_en = 3'b001; load = 3'b001; div_in = 8'd4;
        set_hold(0, 1'b1, 1'b1); set_hold(1, 1'b1, 1'b0); set_hold(2, 1'b1, 1'b0);
        step("ld_pause", 3'b111);
        load = 3'b000;
        for (int e = 1; e <= 2; e++) begin
            set_ch(0, 4, e, 1'b1, 1'b1);
            step("pre_pause", 3'b111);
        end
        ch_en = 3'b000;
        set_hold(0, 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) step("paused", 3'b111);
        ch_en = 3'b001;
        for (int e = 3; e <= 8; e++) begin
            set_ch(0, 4, e, 1'b1, 1'b1);
            step("resume", 3'b111);
        end

        // div=0 stalls, then div=2
        load = 3'b001; div_in = 8'd0;
        set_hold(0, 1'b1, 1'b0);
        step("ld0", 3'b111);
        load = 3'b000;
        for (int n = 0; n < 5; n++) step("div0", 3'b111);
        load = 3'b001; div_in = 8'd2;
        set_hold(0, 1'b1, 1'b1);
        step("ld2", 3'b111);
        load = 3'b000;
        for (int k = 1; k <= 6; k++) begin
            set_ch(0, 2, k, 1'b1, 1'b1);
            step("div2", 3'b111);
        end

        // load on the terminal-count cycle wins
        load = 3'b001; div_in = 8'd4;
        set_hold(0, 1'b0, 1'b1);
        step("ld_t", 3'b111);
        load = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            set_ch(0, 4, k, 1'b0, 1'b1);
            step("to_term", 3'b111);
        end
        load = 3'b001;
        set_hold(0, 1'b0, 1'b1);
        step("ld_term", 3'b111);
        load = 3'b000;
        for (int k = 1; k <= 14; k++) begin
            set_ch(0, 4, k, 1'b0, 1'b1);
            step("after_term", 3'b111);
        end

        // reset mid-count with clk_out[0]=1, then DEF_DIV=6 on all channels
        rst = 1'b1;
        for (int i = 0; i < 3; i++) set_hold(i, 1'b0, 1'b0);
        step("rst_mid", 3'b111);
        rst = 1'b0; ch_en = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            for (int i = 0; i < 3; i++) set_ch(i, 6, k, 1'b0, 1'b1);
            step("def_div", 3'b111);
        end

        // global enable freezes all channels
        en = 1'b0;
        for (int i = 0; i < 3; i++) set_hold(i, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step("en_off", 3'b111);
        en = 1'b1;
        for (int k = 13; k <= 18; k++) begin
            for (int i = 0; i < 3; i++) set_ch(i, 6, k, 1'b0, 1'b1);
            step("en_on", 3'b111);
        end

        // maximum divisor 255 on ch2: single tick, no wrap past div
        ch_en = 3'b100; load = 3'b100; div_in = 8'd255;
        set_hold(0, 1'b1, 1'b0); set_hold(1, 1'b1, 1'b0); set_hold(2, 1'b1, 1'b1);
        step("ld_max", 3'b111);
        load = 3'b000;
        for (int k = 1; k <= 256; k++) begin
            set_ch(2, 255, k, 1'b1, 1'b1);
            step("maxdiv", 3'b111);
        end

        repeat (3) @(negedge clock);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
